// File: rtl/addsub_acc_ctrl.sv
// Accumulator sequencer wrapped around an external combinational add/sub unit.
// The block takes LOAD/ADD/SUB/CLR commands over a valid/ready handshake.
// It drives the adder from registered operands and captures the adder's result and flags.
// It returns the accumulator and flags over a second valid/ready handshake.
// It also keeps a sticky overflow flag and a count of completed ADD/SUB operations.
module addsub_acc_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin,
    input  logic [WIDTH-1:0] add_s,
    input  logic             add_cout,
    input  logic             add_ovf,
    input  logic             add_zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_acc,
    output logic             rsp_cout,
    output logic             rsp_ovf,
    output logic             rsp_zero,
    output logic             ovf_sticky,
    output logic [CNT_W-1:0] op_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;
    localparam logic [1:0] OP_CLR  = 2'b11;

    state_t             state_q,     state_d;
    logic [WIDTH-1:0]   acc_q,       acc_d;
    logic [WIDTH-1:0]   operand_q,   operand_d;
    logic               cin_q,       cin_d;
    logic               rspCout_q,   rspCout_d;
    logic               rspOvf_q,    rspOvf_d;
    logic               rspZero_q,   rspZero_d;
    logic               ovfSticky_q, ovfSticky_d;
    logic [CNT_W-1:0]   opCnt_q,     opCnt_d;

    // Next-state logic: every register holds its value unless the current state says otherwise
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        operand_d   = operand_q;
        cin_d       = cin_q;
        rspCout_d   = rspCout_q;
        rspOvf_d    = rspOvf_q;
        rspZero_d   = rspZero_q;
        ovfSticky_d = ovfSticky_q;
        opCnt_d     = opCnt_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_ADD, OP_SUB: begin
                            operand_d = cmd_data;
                            cin_d     = (cmd_op == OP_SUB);
                            state_d   = EXEC;
                        end
                        OP_LOAD: begin
                            acc_d     = cmd_data;
                            rspCout_d = 1'b0;
                            rspOvf_d  = 1'b0;
                            rspZero_d = (cmd_data == '0);
                            state_d   = RESP;
                        end
                        OP_CLR: begin
                            acc_d       = '0;
                            ovfSticky_d = 1'b0;
                            rspCout_d   = 1'b0;
                            rspOvf_d    = 1'b0;
                            rspZero_d   = 1'b1;
                            state_d     = RESP;
                        end
                        default: state_d = IDLE;
                    endcase
                end
            end
            EXEC: begin
                acc_d       = add_s;
                rspCout_d   = add_cout;
                rspOvf_d    = add_ovf;
                rspZero_d   = add_zero;
                ovfSticky_d = ovfSticky_q | add_ovf;
                opCnt_d     = opCnt_q + 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any in-flight operation
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            operand_q   <= '0;
            cin_q       <= 1'b0;
            rspCout_q   <= 1'b0;
            rspOvf_q    <= 1'b0;
            rspZero_q   <= 1'b0;
            ovfSticky_q <= 1'b0;
            opCnt_q     <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            operand_q   <= operand_d;
            cin_q       <= cin_d;
            rspCout_q   <= rspCout_d;
            rspOvf_q    <= rspOvf_d;
            rspZero_q   <= rspZero_d;
            ovfSticky_q <= ovfSticky_d;
            opCnt_q     <= opCnt_d;
        end
    end

    assign cmd_ready  = (state_q == IDLE);
    assign rsp_valid  = (state_q == RESP);
    assign add_a      = acc_q;
    assign add_b      = operand_q;
    assign add_cin    = cin_q;
    assign rsp_acc    = acc_q;
    assign rsp_cout   = rspCout_q;
    assign rsp_ovf    = rspOvf_q;
    assign rsp_zero   = rspZero_q;
    assign ovf_sticky = ovfSticky_q;
    assign op_cnt     = opCnt_q;

endmodule
